// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared ALU select codes and arbiter state encoding
package alu_arbiter_pkg;

   // Select codes understood by the shared ALU
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   // Arbiter control states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } arb_state_e;

   // Any select code outside the four supported operations is illegal
   function automatic logic is_legal_op(input logic [3:0] op);
      return (op == ALU_AND) || (op == ALU_OR) || (op == ALU_ADD) || (op == ALU_SUB);
   endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter2.sv
// rtl/alu_arbiter_rr_arbiter2.sv - two-way round-robin grant, one-hot output
module rr_arbiter2 (
   input  logic       valid0,
   input  logic       valid1,
   input  logic       last_grant,
   output logic [1:0] grant
);

   // A tie goes to the requester that was not granted last; a lone valid always wins
   always_comb begin
      grant = 2'b00;
      if (valid0 && valid1) begin
         grant = last_grant ? 2'b01 : 2'b10;
      end else begin
         grant = {valid1, valid0};
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester front end time-sharing one external ALU
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [N-1:0] req0_a,
   input  logic [N-1:0] req0_b,
   input  logic [3:0]   req0_op,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [N-1:0] req1_a,
   input  logic [N-1:0] req1_b,
   input  logic [3:0]   req1_op,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   output logic [3:0]   alu_sel,
   input  logic [N-1:0] alu_result,
   input  logic         alu_zero,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [N-1:0] rsp_result,
   output logic         rsp_zero,
   output logic         rsp_err,
   output logic         busy
);

   arb_state_e   state_q, state_d;
   logic         last_q, last_d;
   logic [N-1:0] a_q, a_d;
   logic [N-1:0] b_q, b_d;
   logic [3:0]   op_q, op_d;
   logic         id_q, id_d;
   logic [N-1:0] rsp_result_q, rsp_result_d;
   logic         rsp_zero_q, rsp_zero_d;
   logic         rsp_err_q, rsp_err_d;
   logic         rsp_id_q, rsp_id_d;
   logic [1:0]   grant;
   logic         op_legal;

   rr_arbiter2 u_rr (
      .valid0     (req0_valid),
      .valid1     (req1_valid),
      .last_grant (last_q),
      .grant      (grant)
   );

   assign op_legal = is_legal_op(op_q);

   // Next-state, capture and ALU/response drive for the IDLE -> EXEC -> RESP cycle
   always_comb begin
      state_d      = state_q;
      last_d       = last_q;
      a_d          = a_q;
      b_d          = b_q;
      op_d         = op_q;
      id_d         = id_q;
      rsp_result_d = rsp_result_q;
      rsp_zero_d   = rsp_zero_q;
      rsp_err_d    = rsp_err_q;
      rsp_id_d     = rsp_id_q;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;
      alu_a        = '0;
      alu_b        = '0;
      alu_sel      = 4'b0000;
      rsp_valid    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // rst_n gating keeps both readys low throughout reset
            if (rst_n && (grant != 2'b00)) begin
               req0_ready = grant[0];
               req1_ready = grant[1];
               a_d        = grant[1] ? req1_a  : req0_a;
               b_d        = grant[1] ? req1_b  : req0_b;
               op_d       = grant[1] ? req1_op : req0_op;
               id_d       = grant[1];
               last_d     = grant[1];
               state_d    = ST_EXEC;
            end
         end
         ST_EXEC: begin
            alu_a    = a_q;
            alu_b    = b_q;
            rsp_id_d = id_q;
            state_d  = ST_RESP;
            if (op_legal) begin
               alu_sel      = op_q;
               rsp_result_d = alu_result;
               rsp_zero_d   = alu_zero;
               rsp_err_d    = 1'b0;
            end else begin
               rsp_result_d = '0;
               rsp_zero_d   = 1'b1;
               rsp_err_d    = 1'b1;
            end
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and captured-operand registers; reset drops any in-flight operation
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         last_q       <= 1'b1;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= 4'b0000;
         id_q         <= 1'b0;
         rsp_result_q <= '0;
         rsp_zero_q   <= 1'b0;
         rsp_err_q    <= 1'b0;
         rsp_id_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         a_q          <= a_d;
         b_q          <= b_d;
         op_q         <= op_d;
         id_q         <= id_d;
         rsp_result_q <= rsp_result_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_err_q    <= rsp_err_d;
         rsp_id_q     <= rsp_id_d;
      end
   end

   assign rsp_result = rsp_result_q;
   assign rsp_zero   = rsp_zero_q;
   assign rsp_err    = rsp_err_q;
   assign rsp_id     = rsp_id_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with an external ALU
module tb_alu_arbiter;

   localparam int N = 32;

   typedef struct {
      logic         id;
      logic [N-1:0] res;
      logic         zero;
      logic         err;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         rv [2];
   logic [N-1:0] ra [2];
   logic [N-1:0] rb [2];
   logic [3:0]   rop [2];
   logic         req0_ready, req1_ready;
   logic [N-1:0] alu_a, alu_b, alu_result;
   logic [3:0]   alu_sel;
   logic         alu_zero;
   logic         rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err, busy;
   logic [N-1:0] rsp_result;

   int   n_chk = 0;
   int   n_fail = 0;
   exp_t sb [$];
   exp_t last_rsp;
   int   age = -1;
   logic last_g = 1'b1;
   logic [N-1:0] ex_a, ex_b;
   logic [3:0]   ex_sel;
   bit   rand_rdy = 1'b0;

   alu_arbiter #(.N(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (rv[0]),
      .req0_ready (req0_ready),
      .req0_a     (ra[0]),
      .req0_b     (rb[0]),
      .req0_op    (rop[0]),
      .req1_valid (rv[1]),
      .req1_ready (req1_ready),
      .req1_a     (ra[1]),
      .req1_b     (rb[1]),
      .req1_op    (rop[1]),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_sel    (alu_sel),
      .alu_result (alu_result),
      .alu_zero   (alu_zero),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_zero   (rsp_zero),
      .rsp_err    (rsp_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // The shared ALU lives outside the arbiter; unknown selects return garbage on purpose
   always_comb begin
      case (alu_sel)
         4'b0000: alu_result = alu_a & alu_b;
         4'b0001: alu_result = alu_a | alu_b;
         4'b0010: alu_result = alu_a + alu_b;
         4'b0110: alu_result = alu_a - alu_b;
         default: alu_result = '1;
      endcase
      alu_zero = (alu_result == '0);
   end

   function automatic bit legal(input logic [3:0] op);
      return op inside {4'd0, 4'd1, 4'd2, 4'd6};
   endfunction

   function automatic exp_t model(input logic id, input logic [3:0] op,
                                  input logic [N-1:0] a, input logic [N-1:0] b);
      exp_t e;
      e.id  = id;
      e.err = !legal(op);
      case (op)
         4'd0:    e.res = a & b;
         4'd1:    e.res = a | b;
         4'd2:    e.res = N'(a + b);
         4'd6:    e.res = N'(a - b);
         default: e.res = '0;
      endcase
      e.zero = (e.res == '0);
      return e;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Protocol monitor and scoreboard: grant order, latency, ALU drive, response content
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("reset_readys", {req1_ready, req0_ready}, 2'b00);
         age = -1;
         sb.delete();
         last_g = 1'b1;
         last_rsp = '{id: 1'b0, res: '0, zero: 1'b0, err: 1'b0};
      end else begin
         if (age >= 0) age++;
         if (age < 0) begin
            logic [1:0] exp_g;
            chk("idle_busy", busy, 1'b0);
            chk("idle_rsp_valid", rsp_valid, 1'b0);
            chk("idle_alu", {alu_a, alu_b, alu_sel}, '0);
            chk("idle_rsp_hold", {rsp_id, rsp_zero, rsp_err, rsp_result},
                {last_rsp.id, last_rsp.zero, last_rsp.err, last_rsp.res});
            if (rv[0] && rv[1]) exp_g = last_g ? 2'b01 : 2'b10;
            else                exp_g = {rv[1], rv[0]};
            chk("grant", {req1_ready, req0_ready}, exp_g);
            if (exp_g != 2'b00) begin
               age    = 0;
               last_g = exp_g[1];
               ex_a   = ra[exp_g[1]];
               ex_b   = rb[exp_g[1]];
               ex_sel = legal(rop[exp_g[1]]) ? rop[exp_g[1]] : 4'd0;
            end
         end else if (age == 1) begin
            chk("exec_busy", busy, 1'b1);
            chk("exec_readys", {req1_ready, req0_ready}, 2'b00);
            chk("exec_rsp_valid", rsp_valid, 1'b0);
            chk("exec_alu", {alu_a, alu_b, alu_sel}, {ex_a, ex_b, ex_sel});
            chk("exec_rsp_hold", {rsp_id, rsp_zero, rsp_err, rsp_result},
                {last_rsp.id, last_rsp.zero, last_rsp.err, last_rsp.res});
         end else begin
            chk("resp_busy", busy, 1'b1);
            chk("resp_readys", {req1_ready, req0_ready}, 2'b00);
            chk("resp_valid", rsp_valid, 1'b1);
            chk("resp_alu", {alu_a, alu_b, alu_sel}, '0);
            if (sb.size() == 0) begin
               chk("sb_nonempty", 1'b0, 1'b1);
            end else begin
               chk("rsp_fields", {rsp_id, rsp_zero, rsp_err, rsp_result},
                   {sb[0].id, sb[0].zero, sb[0].err, sb[0].res});
               if (rsp_ready) begin
                  last_rsp = sb.pop_front();
                  age = -1;
               end
            end
         end
      end
   end

   always @(posedge clk) begin
      if (rand_rdy) begin
         #1;
         rsp_ready = ($urandom_range(0, 2) != 0);
      end
   end

   task automatic issue(input int id, input logic [3:0] op,
                        input logic [N-1:0] a, input logic [N-1:0] b);
      bit got = 1'b0;
      ra[id] = a; rb[id] = b; rop[id] = op; rv[id] = 1'b1;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if (rst_n && (id == 0 ? req0_ready : req1_ready)) got = 1'b1;
      end
      chk("issue_accept", got, 1'b1);
      if (got) sb.push_back(model(id[0], op, a, b));
      @(posedge clk);
      #1;
      rv[id] = 1'b0;
   endtask

   task automatic wait_rsp(input logic id, input logic [N-1:0] res,
                           input logic zero, input logic err);
      bit got = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if (rsp_valid && rsp_ready) got = 1'b1;
      end
      chk("rsp_seen", got, 1'b1);
      if (got) begin
         chk("dir_id", rsp_id, id);
         chk("dir_result", rsp_result, res);
         chk("dir_zero", rsp_zero, zero);
         chk("dir_err", rsp_err, err);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic rand_req(input int id);
      logic [3:0]   op;
      logic [N-1:0] a, b;
      for (int k = 0; k < 40; k++) begin
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
         case ($urandom_range(0, 4))
            0: op = 4'd0;
            1: op = 4'd1;
            2: op = 4'd2;
            3: op = 4'd6;
            default: begin
               op = 4'(($urandom_range(0, 15)));
               while (legal(op)) op = 4'(($urandom_range(0, 15)));
            end
         endcase
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? a : $urandom;
         if ($urandom_range(0, 5) == 0) b = N'(-a);
         issue(id, op, a, b);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         rv[i] = 1'b1; ra[i] = '0; rb[i] = '0; rop[i] = 4'd0;
      end
      repeat (3) @(posedge clk);
      #1;
      rv[0] = 1'b0; rv[1] = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_state", {busy, rsp_valid, rsp_id, rsp_zero, rsp_err, rsp_result}, '0);
      @(posedge clk);
      #1;

      // Lone request, ADD 5+7
      issue(0, 4'd2, 32'd5, 32'd7);
      wait_rsp(1'b0, 32'd12, 1'b0, 1'b0);

      // Tie after reset goes to req0 first
      do_reset();
      fork
         issue(0, 4'd6, 32'd9, 32'd9);
         issue(1, 4'd1, 32'h0000_00F0, 32'h0000_000F);
         begin
            wait_rsp(1'b0, 32'd0, 1'b1, 1'b0);
            wait_rsp(1'b1, 32'h0000_00FF, 1'b0, 1'b0);
         end
      join

      // Continuous contention alternates 0,1,0,1
      fork
         begin
            issue(0, 4'd2, 32'd1, 32'd2);
            issue(0, 4'd6, 32'd10, 32'd3);
         end
         begin
            issue(1, 4'd1, 32'h100, 32'h1);
            issue(1, 4'd0, 32'hFF, 32'h0F);
         end
         begin
            wait_rsp(1'b0, 32'd3, 1'b0, 1'b0);
            wait_rsp(1'b1, 32'h101, 1'b0, 1'b0);
            wait_rsp(1'b0, 32'd7, 1'b0, 1'b0);
            wait_rsp(1'b1, 32'h0F, 1'b0, 1'b0);
         end
      join

      // Response back-pressure with another request waiting
      rsp_ready = 1'b0;
      fork
         issue(0, 4'd0, 32'hF0F0, 32'hFF00);
         issue(1, 4'd2, 32'd3, 32'd4);
         begin
            bit seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
               @(negedge clk);
               if (rsp_valid) seen = 1'b1;
            end
            chk("stall_rsp_valid", seen, 1'b1);
            repeat (5) begin
               @(negedge clk);
               chk("stall_readys", {req1_ready, req0_ready}, 2'b00);
               chk("stall_valid", rsp_valid, 1'b1);
               chk("stall_result", rsp_result, 32'hF000);
            end
            @(posedge clk);
            #1;
            rsp_ready = 1'b1;
            wait_rsp(1'b0, 32'hF000, 1'b0, 1'b0);
            wait_rsp(1'b1, 32'd7, 1'b0, 1'b0);
         end
      join

      // Illegal op: error response, ALU select forced to AND
      issue(1, 4'b1111, 32'h1234, 32'h1234);
      wait_rsp(1'b1, 32'd0, 1'b1, 1'b1);

      // Reset while in EXEC drops the operation; a rerun wraps to zero
      issue(0, 4'd2, 32'hFFFF_FFFF, 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("drop_rsp_valid", rsp_valid, 1'b0);
         chk("drop_busy", busy, 1'b0);
      end
      @(posedge clk);
      #1;
      issue(0, 4'd2, 32'hFFFF_FFFF, 32'd1);
      wait_rsp(1'b0, 32'd0, 1'b1, 1'b0);

      // Randomized traffic from both requesters with random back-pressure
      rand_rdy = 1'b1;
      fork
         rand_req(0);
         rand_req(1);
      join
      begin
         bit idle = 1'b0;
         for (int i = 0; i < 2000 && !idle; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !rsp_valid && !busy) idle = 1'b1;
         end
         chk("drain", idle, 1'b1);
      end
      rand_rdy = 1'b0;
      @(posedge clk);
      #2;
      rsp_ready = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
